// File: rtl/ps2_key_pkg.sv
// Shared types and byte constants for the PS/2 scancode trigger decoder.
// Prefix FSM encoding plus classification helpers for the raw byte stream.
package ps2_key_pkg;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_BRK     = 2'd1,
        PFX_EXT     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } pfx_state_e;

    localparam logic [7:0] BYTE_BRK  = 8'hF0;
    localparam logic [7:0] BYTE_EXT  = 8'hE0;
    localparam logic [7:0] BYTE_ACK  = 8'hFA;
    localparam logic [7:0] BYTE_BAT  = 8'hAA;
    localparam logic [7:0] BYTE_ECHO = 8'hEE;
    localparam logic [7:0] BYTE_ERR0 = 8'h00;
    localparam logic [7:0] BYTE_ERRF = 8'hFF;

    // Housekeeping replies from the keyboard that carry no key information.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == BYTE_ACK) || (b == BYTE_BAT) || (b == BYTE_ECHO);
    endfunction

    function automatic logic is_error(input logic [7:0] b);
        return (b == BYTE_ERR0) || (b == BYTE_ERRF);
    endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Make/break/extended prefix tracker with a pending-prefix timeout.
// Decoded code outputs are valid combinationally in the strobe cycle.
module ps2_prefix_fsm
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       data_en_i,
    output logic       code_valid_o,
    output logic [7:0] code_o,
    output logic       is_break_o,
    output logic       is_ext_o,
    output logic       error_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    pfx_state_e    state_q, state_d, eff_state_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_s;

    assign code_o = data_i;

    // A stale prefix is treated as IDLE in the same cycle the counter hits zero.
    always_comb begin
        expired_s    = (state_q != PFX_IDLE) && (cnt_q == CNT_ZERO);
        eff_state_s  = expired_s ? PFX_IDLE : state_q;
        state_d      = eff_state_s;
        cnt_d        = cnt_q;
        code_valid_o = 1'b0;
        is_break_o   = 1'b0;
        is_ext_o     = 1'b0;
        error_o      = 1'b0;
        if (data_en_i) begin
            cnt_d = CNT_RELOAD;
            if (is_ignored(data_i)) begin
                state_d = eff_state_s;
            end else if (is_error(data_i)) begin
                state_d = PFX_IDLE;
                error_o = 1'b1;
            end else begin
                case (eff_state_s)
                    PFX_IDLE: begin
                        if (data_i == BYTE_BRK) begin
                            state_d = PFX_BRK;
                        end else if (data_i == BYTE_EXT) begin
                            state_d = PFX_EXT;
                        end else begin
                            state_d      = PFX_IDLE;
                            code_valid_o = 1'b1;
                        end
                    end
                    PFX_EXT: begin
                        if (data_i == BYTE_BRK) begin
                            state_d = PFX_EXT_BRK;
                        end else begin
                            state_d      = PFX_IDLE;
                            code_valid_o = 1'b1;
                            is_ext_o     = 1'b1;
                        end
                    end
                    PFX_BRK: begin
                        state_d      = PFX_IDLE;
                        code_valid_o = 1'b1;
                        is_break_o   = 1'b1;
                    end
                    PFX_EXT_BRK: begin
                        state_d      = PFX_IDLE;
                        code_valid_o = 1'b1;
                        is_break_o   = 1'b1;
                        is_ext_o     = 1'b1;
                    end
                    default: begin
                        state_d = PFX_IDLE;
                    end
                endcase
            end
        end else begin
            if ((state_q != PFX_IDLE) && (cnt_q != CNT_ZERO)) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Prefix state and timeout counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PFX_IDLE;
            cnt_q   <= CNT_RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_trigger.sv
// PS/2 scancode to multi-channel trigger decoder: held levels plus one-cycle
// trigger/release pulses, immune to typematic repeat.
module ps2_key_trigger
    import ps2_key_pkg::*;
#(
    parameter int                  NUM_CH  = 4,
    parameter logic [NUM_CH*8-1:0] KEYMAP  = 32'h2B231B1C,
    parameter bit                  TOGGLE  = 1'b0,
    parameter int unsigned         TIMEOUT = 50_000_000
) (
    input  logic              CLOCK,
    input  logic              reset_n,
    input  logic [7:0]        received_data,
    input  logic              received_data_en,
    output logic [NUM_CH-1:0] key_held,
    output logic [NUM_CH-1:0] key_trig,
    output logic [NUM_CH-1:0] key_rel,
    output logic [7:0]        last_code,
    output logic              ext_seen
);

    localparam logic [NUM_CH-1:0] CH_ZERO = {NUM_CH{1'b0}};

    logic              code_valid_s;
    logic [7:0]        code_s;
    logic              is_break_s;
    logic              is_ext_s;
    logic              error_s;

    logic [NUM_CH-1:0] held_q, held_d;
    logic [NUM_CH-1:0] down_q, down_d;
    logic [NUM_CH-1:0] trig_q, trig_d;
    logic [NUM_CH-1:0] rel_q, rel_d;
    logic [7:0]        last_q, last_d;
    logic              ext_q, ext_d;

    ps2_prefix_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_prefix (
        .clk_i        (CLOCK),
        .rst_ni       (reset_n),
        .data_i       (received_data),
        .data_en_i    (received_data_en),
        .code_valid_o (code_valid_s),
        .code_o       (code_s),
        .is_break_o   (is_break_s),
        .is_ext_o     (is_ext_s),
        .error_o      (error_s)
    );

    // Channel match and per-channel make/break bookkeeping.
    always_comb begin
        held_d = held_q;
        down_d = down_q;
        trig_d = CH_ZERO;
        rel_d  = CH_ZERO;
        last_d = last_q;
        ext_d  = ext_q;
        if (error_s) begin
            // A corrupted stream loses track of which keys are physically down.
            held_d = CH_ZERO;
            down_d = CH_ZERO;
        end else if (code_valid_s) begin
            last_d = code_s;
            ext_d  = is_ext_s;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!is_ext_s && (KEYMAP[8*i +: 8] == code_s)) begin
                    if (!is_break_s && !down_q[i]) begin
                        down_d[i] = 1'b1;
                        trig_d[i] = 1'b1;
                        held_d[i] = TOGGLE ? ~held_q[i] : 1'b1;
                    end else if (is_break_s && down_q[i]) begin
                        down_d[i] = 1'b0;
                        held_d[i] = TOGGLE ? held_q[i] : 1'b0;
                        rel_d[i]  = TOGGLE ? 1'b0 : 1'b1;
                    end else begin
                        down_d[i] = down_q[i];
                    end
                end else begin
                    down_d[i] = down_q[i];
                end
            end
        end else begin
            held_d = held_q;
        end
    end

    // Output and down-set registers.
    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            held_q <= CH_ZERO;
            down_q <= CH_ZERO;
            trig_q <= CH_ZERO;
            rel_q  <= CH_ZERO;
            last_q <= 8'h00;
            ext_q  <= 1'b0;
        end else begin
            held_q <= held_d;
            down_q <= down_d;
            trig_q <= trig_d;
            rel_q  <= rel_d;
            last_q <= last_d;
            ext_q  <= ext_d;
        end
    end

    assign key_held  = held_q;
    assign key_trig  = trig_q;
    assign key_rel   = rel_q;
    assign last_code = last_q;
    assign ext_seen  = ext_q;

endmodule

// File: tb/tb_ps2_key_trigger.sv
// Bench for ps2_key_trigger: gate and toggle instances share one byte stream,
// checked against a prefix/down-set reference model plus a fixed vector table.
module tb_ps2_key_trigger;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       en = 1'b0;

    logic [3:0] held_g, trig_g, rel_g, held_t, trig_t, rel_t;
    logic [7:0] last_g, last_t;
    logic       ext_g, ext_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ps2_key_trigger #(.NUM_CH(4), .KEYMAP(32'h2B231B1C), .TOGGLE(1'b0), .TIMEOUT(TMO)) dut_g (
        .CLOCK(clk), .reset_n(reset_n), .received_data(data), .received_data_en(en),
        .key_held(held_g), .key_trig(trig_g), .key_rel(rel_g),
        .last_code(last_g), .ext_seen(ext_g)
    );

    ps2_key_trigger #(.NUM_CH(4), .KEYMAP(32'h2B231B1C), .TOGGLE(1'b1), .TIMEOUT(TMO)) dut_t (
        .CLOCK(clk), .reset_n(reset_n), .received_data(data), .received_data_en(en),
        .key_held(held_t), .key_trig(trig_t), .key_rel(rel_t),
        .last_code(last_t), .ext_seen(ext_t)
    );

    // Reference model: pending-prefix flags, time of last byte, set of keys down.
    bit [7:0] km [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
    bit       m_pb, m_pe;
    int       m_last_stb;
    bit [3:0] m_down, m_held_g, m_held_t, m_trig, m_rel;
    bit [7:0] m_last;
    bit       m_ext;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pb = 1'b0; m_pe = 1'b0; m_last_stb = cyc;
        m_down = 4'b0; m_held_g = 4'b0; m_held_t = 4'b0;
        m_trig = 4'b0; m_rel = 4'b0; m_last = 8'h00; m_ext = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit [7:0] d);
        bit valid, isbrk, isext;
        m_trig = 4'b0;
        m_rel  = 4'b0;
        if (!e) return;
        if (cyc - m_last_stb > TMO) begin
            m_pb = 1'b0;
            m_pe = 1'b0;
        end
        m_last_stb = cyc;
        if (d == 8'hFA || d == 8'hAA || d == 8'hEE) return;
        if (d == 8'h00 || d == 8'hFF) begin
            m_pb = 1'b0; m_pe = 1'b0;
            m_held_g = 4'b0; m_held_t = 4'b0; m_down = 4'b0;
            return;
        end
        valid = 1'b0; isbrk = 1'b0; isext = 1'b0;
        if (m_pb) begin
            valid = 1'b1; isbrk = 1'b1; isext = m_pe;
            m_pb = 1'b0; m_pe = 1'b0;
        end else if (d == 8'hF0) begin
            m_pb = 1'b1;
        end else if (d == 8'hE0 && !m_pe) begin
            m_pe = 1'b1;
        end else begin
            valid = 1'b1; isext = m_pe; m_pe = 1'b0;
        end
        if (valid) begin
            m_last = d;
            m_ext  = isext;
            for (int i = 0; i < 4; i++) begin
                if (!isext && km[i] == d) begin
                    if (!isbrk && !m_down[i]) begin
                        m_down[i] = 1'b1; m_trig[i] = 1'b1;
                        m_held_g[i] = 1'b1; m_held_t[i] = ~m_held_t[i];
                    end else if (isbrk && m_down[i]) begin
                        m_down[i] = 1'b0; m_held_g[i] = 1'b0; m_rel[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("g_held", held_g, m_held_g);
        chk("g_trig", trig_g, m_trig);
        chk("g_rel",  rel_g,  m_rel);
        chk("g_last", last_g, m_last);
        chk("g_ext",  ext_g,  m_ext);
        chk("t_held", held_t, m_held_t);
        chk("t_trig", trig_t, m_trig);
        chk("t_rel",  rel_t,  4'b0000);
        chk("t_last", last_t, m_last);
        chk("t_ext",  ext_t,  m_ext);
    endtask

    // One clock cycle: drive at negedge, let the posedge pass, compare at next negedge.
    task automatic tick(input bit e, input bit [7:0] d);
        en = e;
        data = d;
        model_step(e, d);
        @(negedge clk);
        cyc++;
        compare_all();
        en = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic bit [7:0] pick_byte();
        int r = $urandom_range(0, 15);
        if (r < 4) return km[r];
        if (r < 6) return 8'hF0;
        if (r == 6) return 8'hE0;
        if (r == 7) return 8'hFA;
        if (r == 8) return 8'hAA;
        if (r == 9) return 8'hEE;
        return 8'($urandom_range(1, 254));
    endfunction

    typedef struct {
        bit       en;
        bit [7:0] data;
        bit [3:0] held_g;
        bit [3:0] held_t;
        bit [3:0] trig;
        bit [3:0] rel;
        bit [7:0] last;
        bit       ext;
    } vec_t;

    vec_t tbl [23];

    initial begin
        tbl[0]  = '{1'b1, 8'h1C, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 8'h1C, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h1C, 1'b0};
        tbl[2]  = '{1'b1, 8'hF0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h1C, 1'b0};
        tbl[3]  = '{1'b1, 8'h1C, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 8'h1C, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 8'h1C, 1'b0};
        tbl[5]  = '{1'b1, 8'h1B, 4'b0010, 4'b0011, 4'b0010, 4'b0000, 8'h1B, 1'b0};
        tbl[6]  = '{1'b1, 8'h1B, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 8'h1B, 1'b0};
        tbl[7]  = '{1'b1, 8'h1B, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 8'h1B, 1'b0};
        tbl[8]  = '{1'b1, 8'hF0, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 8'h1B, 1'b0};
        tbl[9]  = '{1'b1, 8'h1B, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 8'h1B, 1'b0};
        tbl[10] = '{1'b1, 8'h23, 4'b0100, 4'b0111, 4'b0100, 4'b0000, 8'h23, 1'b0};
        tbl[11] = '{1'b1, 8'hF0, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 8'h23, 1'b0};
        tbl[12] = '{1'b1, 8'h23, 4'b0000, 4'b0111, 4'b0000, 4'b0100, 8'h23, 1'b0};
        tbl[13] = '{1'b1, 8'h23, 4'b0100, 4'b0011, 4'b0100, 4'b0000, 8'h23, 1'b0};
        tbl[14] = '{1'b1, 8'hF0, 4'b0100, 4'b0011, 4'b0000, 4'b0000, 8'h23, 1'b0};
        tbl[15] = '{1'b1, 8'h23, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 8'h23, 1'b0};
        tbl[16] = '{1'b1, 8'hE0, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 8'h23, 1'b0};
        tbl[17] = '{1'b1, 8'h1C, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 8'h1C, 1'b1};
        tbl[18] = '{1'b1, 8'hFA, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 8'h1C, 1'b1};
        tbl[19] = '{1'b1, 8'hAA, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 8'h1C, 1'b1};
        tbl[20] = '{1'b1, 8'hEE, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 8'h1C, 1'b1};
        tbl[21] = '{1'b1, 8'h2B, 4'b1000, 4'b1011, 4'b1000, 4'b0000, 8'h2B, 1'b0};
        tbl[22] = '{1'b1, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h2B, 1'b0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].en, tbl[i].data);
            chk($sformatf("tbl%0d_held_g", i), held_g, tbl[i].held_g);
            chk($sformatf("tbl%0d_held_t", i), held_t, tbl[i].held_t);
            chk($sformatf("tbl%0d_trig_g", i), trig_g, tbl[i].trig);
            chk($sformatf("tbl%0d_trig_t", i), trig_t, tbl[i].trig);
            chk($sformatf("tbl%0d_rel_g", i),  rel_g,  tbl[i].rel);
            chk($sformatf("tbl%0d_last", i),   last_g, tbl[i].last);
            chk($sformatf("tbl%0d_ext", i),    ext_g,  tbl[i].ext);
        end

        // Prefix still pending exactly TIMEOUT cycles after F0: byte is a break.
        tick(1'b1, 8'h2B);
        chk("tmo_setup_trig", trig_g, 4'b1000);
        tick(1'b1, 8'hF0);
        for (int k = 0; k < TMO - 1; k++) tick(1'b0, 8'h00);
        tick(1'b1, 8'h2B);
        chk("tmo_edge_break_rel", rel_g, 4'b1000);
        chk("tmo_edge_break_held", held_g, 4'b0000);

        // One cycle later the prefix has expired: byte is a fresh make.
        tick(1'b1, 8'hF0);
        for (int k = 0; k < TMO; k++) tick(1'b0, 8'h00);
        tick(1'b1, 8'h2B);
        chk("tmo_expired_make_trig", trig_g, 4'b1000);
        chk("tmo_expired_make_rel", rel_g, 4'b0000);

        // Reset while a break prefix is pending and a key is down.
        do_reset();
        tick(1'b1, 8'h1C);
        tick(1'b1, 8'hF0);
        do_reset();
        chk("rst_held_clear", held_g, 4'b0000);
        chk("rst_last_clear", last_g, 8'h00);
        tick(1'b1, 8'h1C);
        chk("rst_fresh_trig", trig_g, 4'b0001);
        chk("rst_fresh_held", held_g, 4'b0001);

        for (int n = 0; n < 2500; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) begin
                int len = $urandom_range(TMO - 5, TMO + 5);
                for (int k = 0; k < len; k++) tick(1'b0, 8'h00);
            end else if (r < 50) begin
                tick(1'b0, 8'h00);
            end else begin
                tick(1'b1, pick_byte());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
